// File: rtl/pcs_tx_gearbox_param.sv
// pcs_tx_gearbox_param: packs 66-bit PCS blocks (header + payload) into a continuous
// LSB-first bit stream and emits it as DATA_WIDTH-bit words with valid/ready handshakes.
// Optional build macro: PCS_TX_GEARBOX_SCRAMBLE_EN adds a 1+x^39+x^58 self-synchronous
// payload scrambler applied as each block is accepted.
module pcs_tx_gearbox_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUF_W      = 2*DATA_WIDTH+66
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [1:0]                 i_blk_hdr,
    input  logic [63:0]                i_blk_data,
    input  logic                       i_blk_valid,
    output logic                       o_blk_ready,
    output logic [DATA_WIDTH-1:0]      o_tx_data,
    output logic                       o_tx_valid,
    input  logic                       i_tx_ready,
    output logic [$clog2(BUF_W+1)-1:0] o_fill
);
    localparam int unsigned BLK_W = 66;
    localparam int unsigned CNT_W = $clog2(BUF_W+1);

    // Reject unsupported widths and any override of the derived buffer size.
    if (!(DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
        $error("pcs_tx_gearbox_param: DATA_WIDTH must be 16, 32 or 64");
    end
    if (BUF_W != 2*DATA_WIDTH+BLK_W) begin : g_bad_buf
        $error("pcs_tx_gearbox_param: BUF_W is derived and must not be overridden");
    end

    logic [BUF_W-1:0]      buf_q, buf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  acc, fire;
    logic [63:0]           payload;

    assign acc  = i_blk_valid & ready_q;
    assign fire = valid_q & i_tx_ready;

`ifdef PCS_TX_GEARBOX_SCRAMBLE_EN
    logic [57:0] lfsr_q, lfsr_d;

    // Scramble payload bits data[0]..data[63] in order; LFSR advances only on acceptance.
    always_comb begin
        logic [57:0] s;
        logic        sb;
        s       = lfsr_q;
        sb      = 1'b0;
        payload = i_blk_data;
        for (int i = 0; i < 64; i++) begin
            sb         = i_blk_data[i] ^ s[57] ^ s[38];
            payload[i] = sb;
            s          = {s[56:0], sb};
        end
        lfsr_d = acc ? s : lfsr_q;
    end

    // Scrambler state register, all ones out of reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            lfsr_q <= '1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign payload = i_blk_data;
`endif

    // Shift out a word on fire, then append an accepted block behind the remaining bits.
    always_comb begin
        logic [BUF_W-1:0] shifted;
        logic [CNT_W-1:0] base;
        shifted = buf_q;
        base    = cnt_q;
        if (fire) begin
            shifted = buf_q >> DATA_WIDTH;
            base    = cnt_q - CNT_W'(DATA_WIDTH);
        end
        buf_d = shifted;
        cnt_d = base;
        if (acc) begin
            buf_d = shifted | (BUF_W'({payload, i_blk_hdr}) << base);
            cnt_d = base + CNT_W'(BLK_W);
        end
        valid_d = (cnt_d >= CNT_W'(DATA_WIDTH));
        ready_d = (cnt_d <= CNT_W'(2*DATA_WIDTH));
        data_d  = buf_d[DATA_WIDTH-1:0];
    end

    // Buffer, fill count and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            data_q  <= '0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign o_blk_ready = ready_q;
    assign o_tx_valid  = valid_q;
    assign o_tx_data   = data_q;
    assign o_fill      = cnt_q;

endmodule
